// File: rtl/pipes_pkg.sv
// Shared pipeline types: fetch FSM state encoding, the fetch/decode register
// layout and the architectural reset PC.
package pipes_pkg;

  localparam logic [63:0] PC_RESET_DEFAULT = 64'h8000_0000;
  localparam logic [63:0] INSTR_BYTES      = 64'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } fetch_data_t;

  // Sequential successor; wraps silently at the top of the 64-bit space.
  function automatic logic [63:0] nextSeqPc(input logic [63:0] pc);
    return pc + INSTR_BYTES;
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch controller feeding one fetch/decode
// register; supports redirects, including while a stale request is in flight.
module fetch_ctrl
  import pipes_pkg::*;
#(
  parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        fd_valid,
  output logic [31:0] fd_instr,
  output logic [63:0] fd_pc,
  input  logic        fd_ready,
  input  logic        redirect,
  input  logic [63:0] redirect_pc
);

  fetch_state_t r_state;
  logic [63:0]  r_pc;
  logic [63:0]  r_reqAddr;
  logic         r_reqValid;
  logic         r_fdValid;
  fetch_data_t  r_fd;

  fetch_state_t w_nextState;
  logic [63:0]  w_nextPc;
  logic [63:0]  w_nextReqAddr;
  fetch_data_t  w_nextFd;
  logic [63:0]  w_drainTarget;

  // In DRAIN r_pc holds the restart address while r_reqAddr keeps the stale
  // address on the bus until its response arrives and is thrown away.
  always_comb begin
    w_nextState   = r_state;
    w_nextPc      = r_pc;
    w_nextReqAddr = r_reqAddr;
    w_nextFd      = r_fd;
    w_drainTarget = redirect ? redirect_pc : r_pc;
    case (r_state)
      IDLE: begin
        w_nextState   = REQ;
        w_nextPc      = PC_RESET;
        w_nextReqAddr = PC_RESET;
      end
      REQ: begin
        if (iresp_data_ok && redirect) begin
          w_nextPc      = redirect_pc;
          w_nextReqAddr = redirect_pc;
        end else if (iresp_data_ok) begin
          w_nextFd    = '{instr: iresp_data, pc: r_pc};
          w_nextState = HOLD;
        end else if (redirect) begin
          w_nextPc    = redirect_pc;
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        w_nextPc = w_drainTarget;
        if (iresp_data_ok) begin
          w_nextReqAddr = w_drainTarget;
          w_nextState   = REQ;
        end
      end
      HOLD: begin
        // A redirect beats a simultaneous accept: the instruction is squashed.
        if (redirect) begin
          w_nextPc      = redirect_pc;
          w_nextReqAddr = redirect_pc;
          w_nextState   = REQ;
        end else if (fd_ready) begin
          w_nextPc      = nextSeqPc(r_fd.pc);
          w_nextReqAddr = nextSeqPc(r_fd.pc);
          w_nextState   = REQ;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc       <= PC_RESET;
      r_reqAddr  <= '0;
      r_reqValid <= 1'b0;
      r_fdValid  <= 1'b0;
      r_fd       <= '0;
    end else begin
      r_state    <= w_nextState;
      r_pc       <= w_nextPc;
      r_reqAddr  <= w_nextReqAddr;
      r_reqValid <= (w_nextState == REQ) || (w_nextState == DRAIN);
      r_fdValid  <= (w_nextState == HOLD);
      r_fd       <= w_nextFd;
    end
  end

  assign ireq_valid = r_reqValid;
  assign ireq_addr  = r_reqAddr;
  assign fd_valid   = r_fdValid;
  assign fd_instr   = r_fd.instr;
  assign fd_pc      = r_fd.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the fetch unit.
module tb_fetch_ctrl;

  localparam logic [63:0] PC_RST = 64'h8000_0000;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        fd_valid;
  logic [31:0] fd_instr;
  logic [63:0] fd_pc;
  logic        fd_ready;
  logic        redirect;
  logic [63:0] redirect_pc;

  int testCount = 0;
  int failCount = 0;

  // Model: one possibly-outstanding bus access, whether its reply is doomed,
  // where fetch resumes afterwards, and the instruction parked for decode.
  bit          mStarting;
  bit          mBusy;
  logic [63:0] mBusAddr;
  bit          mDoomed;
  logic [63:0] mResume;
  bit          mHeld;
  logic [31:0] mHeldInstr;
  logic [63:0] mHeldPc;

  fetch_ctrl #(.PC_RESET(PC_RST)) dut (
    .clk          (clk),
    .reset        (reset),
    .ireq_valid   (ireq_valid),
    .ireq_addr    (ireq_addr),
    .iresp_data_ok(iresp_data_ok),
    .iresp_data   (iresp_data),
    .fd_valid     (fd_valid),
    .fd_instr     (fd_instr),
    .fd_pc        (fd_pc),
    .fd_ready     (fd_ready),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mStarting  = 1'b1;
    mBusy      = 1'b0;
    mBusAddr   = '0;
    mDoomed    = 1'b0;
    mResume    = PC_RST;
    mHeld      = 1'b0;
    mHeldInstr = '0;
    mHeldPc    = '0;
  endtask

  task automatic modelStep();
    if (reset) begin
      modelReset();
    end else if (mStarting) begin
      mStarting = 1'b0;
      mBusy     = 1'b1;
      mBusAddr  = PC_RST;
    end else if (mHeld) begin
      if (redirect) begin
        mHeld = 1'b0; mBusy = 1'b1; mBusAddr = redirect_pc;
      end else if (fd_ready) begin
        mHeld = 1'b0; mBusy = 1'b1; mBusAddr = mHeldPc + 64'd4;
      end
    end else if (mBusy && !mDoomed) begin
      if (iresp_data_ok && redirect) begin
        mBusAddr = redirect_pc;
      end else if (iresp_data_ok) begin
        mBusy = 1'b0; mHeld = 1'b1; mHeldInstr = iresp_data; mHeldPc = mBusAddr;
      end else if (redirect) begin
        mDoomed = 1'b1; mResume = redirect_pc;
      end
    end else if (mBusy && mDoomed) begin
      if (redirect) mResume = redirect_pc;
      if (iresp_data_ok) begin
        mDoomed  = 1'b0;
        mBusAddr = mResume;
      end
    end
  endtask

  task automatic checkModel();
    checkOutput("ireq_valid", {63'd0, ireq_valid}, {63'd0, mBusy});
    if (mBusy) checkOutput("ireq_addr", ireq_addr, mBusAddr);
    checkOutput("fd_valid", {63'd0, fd_valid}, {63'd0, mHeld});
    if (mHeld) begin
      checkOutput("fd_instr", {32'd0, fd_instr}, {32'd0, mHeldInstr});
      checkOutput("fd_pc", fd_pc, mHeldPc);
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then compare.
  task automatic applyStimulus(input logic ok, input logic [31:0] data,
                               input logic rdy, input logic rd,
                               input logic [63:0] rpc);
    iresp_data_ok = ok;
    iresp_data    = data;
    fd_ready      = rdy;
    redirect      = rd;
    redirect_pc   = rpc;
    @(posedge clk);
    modelStep();
    #1;
    checkModel();
  endtask

  initial begin
    reset = 1'b1;
    iresp_data_ok = 1'b0; iresp_data = '0; fd_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    modelReset();

    // Reset state
    repeat (2) applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h1234);
    checkOutput("rst_ireq_addr", ireq_addr, 64'd0);
    checkOutput("rst_fd_instr", {32'd0, fd_instr}, 64'd0);
    checkOutput("rst_fd_pc", fd_pc, 64'd0);
    reset = 1'b0;

    // First fetch after reset
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("boot_addr", ireq_addr, 64'h8000_0000);
    checkOutput("boot_valid", {63'd0, ireq_valid}, 64'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 32'h0010_0093, 1'b0, 1'b0, '0);
    checkOutput("boot_fd_valid", {63'd0, fd_valid}, 64'd1);
    checkOutput("boot_fd_pc", fd_pc, 64'h8000_0000);
    checkOutput("boot_fd_instr", {32'd0, fd_instr}, 64'h0010_0093);

    // Stall in HOLD, stray responses ignored, then fire
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i[0], 32'hBAD0_0000, 1'b0, 1'b0, '0);
      checkOutput("stall_instr", {32'd0, fd_instr}, 64'h0010_0093);
      checkOutput("stall_nreq", {63'd0, ireq_valid}, 64'd0);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
    checkOutput("seq_addr", ireq_addr, 64'h8000_0004);

    // Redirect with the old request still in flight
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 64'h8000_0100);
    checkOutput("drain_addr0", ireq_addr, 64'h8000_0004);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("drain_addr2", ireq_addr, 64'h8000_0004);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);
    checkOutput("drain_new_addr", ireq_addr, 64'h8000_0100);
    checkOutput("drain_dropped", {63'd0, fd_valid}, 64'd0);

    // Redirect beats fd_ready in HOLD
    applyStimulus(1'b1, 32'h1234_5678, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 64'h8000_0200);
    checkOutput("hold_rd_fdv", {63'd0, fd_valid}, 64'd0);
    checkOutput("hold_rd_addr", ireq_addr, 64'h8000_0200);

    // Redirect coinciding with data, then PC wrap on fire
    applyStimulus(1'b1, 32'hAAAA_AAAA, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("rd_ok_addr", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(1'b1, 32'h0000_0013, 1'b0, 1'b0, '0);
    checkOutput("top_fd_pc", fd_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
    checkOutput("wrap_addr", ireq_addr, 64'd0);

    // Asynchronous reset while draining
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 64'h8000_0300);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_nreq", {63'd0, ireq_valid}, 64'd0);
    checkOutput("async_nfd", {63'd0, fd_valid}, 64'd0);
    modelReset();
    applyStimulus(1'b1, 32'h5555_5555, 1'b1, 1'b0, '0);
    reset = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("restart_addr", ireq_addr, 64'h8000_0000);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] rpc;
      rpc = ($urandom_range(0, 7) == 0) ?
            (64'hFFFF_FFFF_FFFF_FFF0 | {60'd0, $urandom_range(0, 3), 2'b00}) :
            {32'd0, $urandom} & ~64'd3;
      reset = ($urandom_range(0, 249) == 0);
      applyStimulus($urandom_range(0, 9) < 4, $urandom,
                    $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0, rpc);
      reset = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter PC_RESET, default 64'h8000_0000, SHALL give the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 ireq_valid  output  1  SHALL indicate that an instruction fetch request is active.
REQ-005 ireq_addr  output  64  SHALL carry the fetch address (u64).
REQ-006 iresp_data_ok  input  1  SHALL indicate that the instruction bus returns data this cycle.
REQ-007 iresp_data  input  32  SHALL carry the fetched instruction (u32).
REQ-008 fd_valid  output  1  SHALL indicate that the fetch/decode register holds a live instruction.
REQ-009 fd_instr  output  32  SHALL be the instruction presented to the decoder.
REQ-010 fd_pc  output  64  SHALL be the PC of fd_instr.
REQ-011 fd_ready  input  1  SHALL indicate that decode accepts fd_instr this cycle.
REQ-012 redirect  input  1  SHALL request a fetch restart (branch or flush).
REQ-013 redirect_pc  input  64  SHALL give the restart address; it SHALL be sampled only when redirect=1.

Function
REQ-014 FSM states SHALL be IDLE, REQ, HOLD and DRAIN.
REQ-015 IDLE SHALL last exactly one cycle after reset release and then go to REQ with pc=PC_RESET.
REQ-016 In REQ: ireq_valid=1 and ireq_addr=pc; address SHALL stay stable until iresp_data_ok.
REQ-017 REQ with iresp_data_ok=1 and redirect=0: latch iresp_data/pc into fd_instr/fd_pc, go HOLD; fd_valid=1 on the next cycle (1-cycle latency).
REQ-018 REQ with redirect=1 and iresp_data_ok=1 (same cycle): response dropped, pc<=redirect_pc, stay REQ.
REQ-019 REQ with redirect=1 and iresp_data_ok=0: pc<=redirect_pc, go DRAIN; ireq_valid and ireq_addr SHALL be held at the old address until iresp_data_ok.
REQ-020 In DRAIN: on iresp_data_ok the response SHALL be discarded, go REQ at the stored redirect pc.
REQ-021 In DRAIN: a further redirect SHALL overwrite the stored redirect pc; the newest redirect wins.
REQ-022 In HOLD: fd_valid=1 and ireq_valid=0.
REQ-023 In HOLD, fd_ready=1 and redirect=0 is a fire: pc<=fd_pc+4 (64-bit wrap, no carry out), fd_valid<=0, go REQ.
REQ-024 In HOLD, redirect=1 (regardless of fd_ready): the instruction SHALL NOT count as consumed; fd_valid<=0, pc<=redirect_pc, go REQ.
REQ-025 HOLD with fd_ready=0 SHALL hold fd_instr/fd_pc unchanged indefinitely.
REQ-026 fd_valid SHALL be 1 only in HOLD; at most one request SHALL be outstanding; no prefetch.
REQ-027 Any iresp_data_ok outside REQ/DRAIN SHALL be ignored.

Reset
REQ-028 While reset=1: state=IDLE, pc=PC_RESET, ireq_valid=0, ireq_addr=0, fd_valid=0, fd_instr=0, fd_pc=0, all forced asynchronously.
REQ-029 Reset mid-operation SHALL abandon any outstanding request or held instruction with no further bus activity until after IDLE.

Structure
REQ-030 The fetch_state_t enum and PC_RESET default SHALL live in the shared pipes package; the fetch/decode register SHALL be a pipes struct fetch_data_t {instr u32, pc u64}.
REQ-031 No sub-module is needed; fetch_ctrl SHALL be a single module with one always_ff and one always_comb next-state block.

Verification
REQ-032 Reset release, data_ok 2 cycles later with 32'h0010_0093 -> ireq_addr=8000_0000; fd_valid=1, fd_pc=8000_0000, fd_instr=0010_0093 one cycle after data_ok.
REQ-033 HOLD, fd_ready=0 for 5 cycles then 1 -> fd_* stable for 5 cycles; next ireq_addr=8000_0004.
REQ-034 REQ at 8000_0004, redirect to 8000_0100 with no data_ok, data_ok 3 cycles later -> ireq_addr stays 8000_0004 until data_ok; data discarded; next request 8000_0100.
REQ-035 HOLD with fd_ready=1 and redirect=1 to 8000_0200 in the same cycle -> fd_valid=0 next cycle; next request 8000_0200, not fd_pc+4.
REQ-036 Redirect to FFFF_FFFF_FFFF_FFFC, then fire -> next ireq_addr=0 (wrap).
REQ-037 Assert reset during DRAIN -> ireq_valid=0 and fd_valid=0 immediately (same cycle); after release fetch restarts at 8000_0000.
